// File: rtl/fifo_nd_fwft.sv
// ---------------------------------------------------------------------------
// fifo_nd_fwft
//
// N-deep first-word-fall-through FIFO for valid/ready request and response
// paths. The head entry sits on b_data whenever b_valid is high, so no read
// strobe is needed. A push and a pop may complete in the same cycle, which
// gives one transfer per cycle at every occupancy except full (no push) and
// empty (no pop). All handshake flags are registered.
//
// Parameters
//   WIDTH        payload width in bits (>= 1)
//   DEPTH        number of entries, a power of two, >= 2
//   AFULL_LEVEL  occupancy at or above which almost_full asserts (1..DEPTH)
//   CW           width of count, derived from DEPTH (do not override)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   flush        synchronous clear; voids every handshake in its cycle
//   a_data       write payload
//   a_valid      write request
//   a_ready      FIFO can accept a word (registered)
//   b_data       head entry, meaningful while b_valid is high
//   b_valid      FIFO holds at least one entry (registered)
//   b_ready      consumer takes the head entry
//   count        current occupancy, 0..DEPTH (registered)
//   almost_full  count >= AFULL_LEVEL (registered)
// ---------------------------------------------------------------------------
module fifo_nd_fwft #(
    parameter int WIDTH       = 113,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

    // Storage carries no reset; only the control state below is reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          a_ready_q, a_ready_d;
    logic          b_valid_q, b_valid_d;
    logic          afull_q, afull_d;

    logic push;
    logic pop;

    // Handshakes are qualified by the registered flags, so a full FIFO never
    // borrows the slot freed by a same-cycle pop and an empty FIFO never
    // forwards a_data straight to b_data. a_ready_q is low throughout reset,
    // which also keeps the unreset memory from being written then.
    assign push = a_valid && a_ready_q && !flush;
    assign pop  = b_valid_q && b_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits wide and wrap for free.
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Flags come from the next-state occupancy so they are registered
        // yet exact in the cycle the new count takes effect. Full and empty
        // are told apart by the count, never by pointer equality.
        a_ready_d = (count_d != DEPTH_C);
        b_valid_d = (count_d != '0);
        afull_d   = (count_d >= AFULL_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            a_ready_q <= 1'b0;
            b_valid_q <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            a_ready_q <= a_ready_d;
            b_valid_q <= b_valid_d;
            afull_q   <= afull_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= a_data;
        end
    end

    // First-word fall-through: the head is read combinationally.
    assign b_data      = mem_q[rd_ptr_q];
    assign a_ready     = a_ready_q;
    assign b_valid     = b_valid_q;
    assign count       = count_q;
    assign almost_full = afull_q;

endmodule

// File: tb/tb_fifo_nd_fwft.sv
module tb_fifo_nd_fwft;

    localparam int W   = 113;
    localparam int D   = 4;
    localparam int AFL = D - 1;
    localparam int CWT = $clog2(D + 1);

    logic           clk     = 1'b0;
    logic           rst     = 1'b0;
    logic           flush   = 1'b0;
    logic [W-1:0]   a_data  = '0;
    logic           a_valid = 1'b0;
    logic           a_ready;
    logic [W-1:0]   b_data;
    logic           b_valid;
    logic           b_ready = 1'b0;
    logic [CWT-1:0] count;
    logic           almost_full;

    int errors = 0;
    int checks = 0;

    // Reference model: the FIFO contents as a plain queue plus the expected
    // registered a_ready. Occupancy, b_valid and almost_full follow from the
    // queue length.
    logic [W-1:0] sb_q[$];
    bit           m_ready = 1'b0;

    fifo_nd_fwft #(
        .WIDTH      (W),
        .DEPTH      (D),
        .AFULL_LEVEL(AFL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .a_data     (a_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_data     (b_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .count      (count),
        .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    // Model update on the active edge: accepted writes enter the queue,
    // flush empties it. Pops are taken by the monitor.
    always @(posedge clk) begin
        if (rst) begin
            if (flush) begin
                sb_q.delete();
            end else if (a_valid && m_ready) begin
                sb_q.push_back(a_data);
            end
            m_ready = (sb_q.size() != D);
        end
    end

    always @(negedge rst) begin
        sb_q.delete();
        m_ready = 1'b0;
    end

    // Monitor on the falling edge: flags against the model, and whenever the
    // consumer takes a word, the head against the oldest expected entry.
    always @(negedge clk) begin
        int unsigned sz;
        sz = sb_q.size();
        check("count", 128'(count), 128'(sz));
        check("b_valid", 128'(b_valid), 128'(sz != 0));
        check("a_ready", 128'(a_ready), 128'(m_ready));
        check("almost_full", 128'(almost_full), 128'(sz >= AFL));
        if (rst && !flush && b_ready && (sz != 0 || b_valid)) begin
            if (sz == 0) begin
                checks++;
                errors++;
                $display("FAIL b_data: got unexpected word 0x%0h, expected none", b_data);
            end else begin
                check("b_data", 128'(b_data), 128'(sb_q[0]));
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset / idle
        rst = 1'b0;
        repeat (3) tick();
        check("a_ready_in_reset", 128'(a_ready), 128'(0));
        rst = 1'b1;
        tick();
        check("a_ready_after_release", 128'(a_ready), 128'(1));
        check("count_after_release", 128'(count), 128'(0));

        // Fill with the consumer stalled, then a refused fifth word
        for (int i = 1; i <= 4; i++) begin
            a_valid = 1'b1;
            a_data  = W'(i);
            tick();
        end
        check("count_full", 128'(count), 128'(4));
        check("a_ready_full", 128'(a_ready), 128'(0));
        a_data = W'(5);
        tick();
        check("count_still_full", 128'(count), 128'(4));
        a_valid = 1'b0;
        b_ready = 1'b1;
        repeat (4) tick();
        check("b_valid_drained", 128'(b_valid), 128'(0));
        b_ready = 1'b0;
        tick();

        // Streaming through several pointer wraps
        a_valid = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_data = W'(32'h100 + i);
            tick();
        end
        check("count_streaming", 128'(count), 128'(1));
        a_valid = 1'b0;
        repeat (2) tick();
        b_ready = 1'b0;

        // Simultaneous push/pop at count 3, then at full
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = W'(32'h200 + i);
            tick();
        end
        b_ready = 1'b1;
        a_data  = W'(32'h203);
        tick();
        check("count_pushpop_3", 128'(count), 128'(3));
        b_ready = 1'b0;
        a_data  = W'(32'h204);
        tick();
        check("count_to_full", 128'(count), 128'(4));
        b_ready = 1'b1;
        a_data  = W'(32'h205);
        tick();
        check("count_full_pop_only", 128'(count), 128'(3));

        // Flush at count 3 with both handshakes requested
        flush  = 1'b1;
        a_data = W'(32'hDEAD);
        tick();
        flush   = 1'b0;
        a_valid = 1'b0;
        b_ready = 1'b0;
        check("count_after_flush", 128'(count), 128'(0));
        check("b_valid_after_flush", 128'(b_valid), 128'(0));
        check("a_ready_after_flush", 128'(a_ready), 128'(1));
        tick();

        // Asynchronous reset in mid-cycle at count 2
        a_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_data = W'(32'h300 + i);
            tick();
        end
        a_valid = 1'b0;
        check("count_before_async", 128'(count), 128'(2));
        #2;
        rst = 1'b0;
        #1;
        check("async_count", 128'(count), 128'(0));
        check("async_b_valid", 128'(b_valid), 128'(0));
        check("async_a_ready", 128'(a_ready), 128'(0));
        check("async_almost_full", 128'(almost_full), 128'(0));
        tick();
        tick();
        rst = 1'b1;
        tick();
        a_valid = 1'b1;
        a_data  = W'(32'hABC);
        tick();
        a_data  = W'(32'hABD);
        b_ready = 1'b1;
        check("first_after_reset", 128'(b_data), 128'(32'hABC));
        tick();
        a_valid = 1'b0;
        repeat (2) tick();
        b_ready = 1'b0;

        // Randomised traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            a_data  = rnd_word();
            tick();
        end

        // Drain
        flush   = 1'b0;
        a_valid = 1'b0;
        b_ready = 1'b1;
        repeat (8) tick();
        check("final_b_valid", 128'(b_valid), 128'(0));
        check("final_count", 128'(count), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_nd_fwft.md
# fifo_nd_fwft

Parametrised N-deep first-word-fall-through FIFO, the general successor of the 1-deep request queue between the memory-link bridge and the system bus. It sits on valid/ready request or response paths (KL bus side) where multiple outstanding transactions, or more than the I/D cache masters, must be buffered without back-pressure bubbles. It adds configurable width and depth, full-throughput simultaneous push/pop, an occupancy count, an almost-full flag and a synchronous flush.

## Interface

Parameters:
- WIDTH, 113, payload width in bits (matches the packed KL request: addr, wen, wdata, wmask, size, srcid); legal range is 1 or more.
- DEPTH, 4, number of entries; must be a power of two and 2 or more.
- AFULL_LEVEL, DEPTH-1, occupancy at or above which `almost_full` asserts; legal range is 1 to DEPTH.
- CW, $clog2(DEPTH+1), width of `count` (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Assertion takes effect immediately. Deassertion is synchronised by the integrator.
- flush  in  1  synchronous clear; discards all entries.
- a_data  in  WIDTH  write payload.
- a_valid  in  1  write request.
- a_ready  out  1  FIFO can accept; registered.
- b_data  out  WIDTH  head entry; valid whenever `b_valid` is 1.
- b_valid  out  1  FIFO non-empty; registered.
- b_ready  in  1  consumer takes head.
- count  out  CW  current occupancy, 0 to DEPTH; registered.
- almost_full  out  1  high when `count` is AFULL_LEVEL or more; registered.

## Operation

- Storage is a DEPTH×WIDTH register array with no reset. Read and write pointers are log2(DEPTH) bits each and wrap naturally modulo DEPTH.
- Push: `a_valid && a_ready && !flush`. It writes `a_data` to mem[wr_ptr], then wr_ptr increments.
- Pop: `b_valid && b_ready && !flush`. Then rd_ptr increments.
- `b_data` = mem[rd_ptr] (combinational read). The head is visible with no read strobe (FWFT).
- Count update:
  - push only: +1
  - pop only: −1
  - both, or neither: unchanged.
- Push and pop in the same cycle are legal at any occupancy from 1 to DEPTH−1.
  - When full, `a_ready`=0, so no push occurs; there is no pass-through of a pop slot to a push within a cycle.
  - When empty, `b_valid`=0, so no pop occurs; there is no combinational bypass from `a_data` to `b_data`.
- Registered flag updates, computed from next-state count n:
  - `a_ready` ← (n != DEPTH)
  - `b_valid` ← (n != 0)
  - `almost_full` ← (n ≥ AFULL_LEVEL)
  - `count` ← n
- Flush: all handshakes in that cycle are void. Next cycle: pointers=0, count=0, `b_valid`=0, `a_ready`=1, `almost_full`=(AFULL_LEVEL==0 ? 1 : 0), i.e. 0 for legal values. Memory contents are not cleared.
- Protocol rule: `a_data` may change freely while `a_ready`=0. While `b_valid`=1 and no pop occurs, `b_data` is stable.

## Timing

- Reset values while `rst`=0: `a_ready`=0, `b_valid`=0, `count`=0, `almost_full`=0, both pointers=0. `b_data` is don't-care and must not be checked while `b_valid`=0.
- `a_ready` rises on the first rising clk edge after `rst` deasserts.
- Latency: an entry pushed at edge k appears with `b_valid`=1 and correct `b_data` after edge k. It can be popped in cycle k+1, giving a minimum write-to-read latency of 1 cycle.
- Throughput: 1 transfer per cycle sustained in and out at every occupancy except full (out only) and empty (in only).
- Reset mid-operation: all entries are lost and outputs return to reset values asynchronously. No handshake completes in a cycle where `rst`=0.
- Wrap-around: ordering is preserved across pointer wrap. Full is distinguished from empty by `count`, not by pointer equality.

## Test plan

- Reset/idle: hold rst=0 for 3 cycles, then release -> `a_ready`=0 during reset and 1 one edge after release; `b_valid`=0 and `count`=0 throughout.
- Fill/drain (DEPTH=4): push 0x1,0x2,0x3,0x4 on consecutive cycles with b_ready=0 -> `count` goes 1,2,3,4; `almost_full` first asserts at count=3; `a_ready`=0 at count=4; a 5th a_valid is not accepted. Then b_ready=1 -> outputs 0x1..0x4 in order, one per cycle, ending with `b_valid`=0.
- Streaming: a_valid=b_ready=1 for 20 cycles with an incrementing payload -> `count` settles at 1, no bubble after the first output, data sequence exact, pointers wrap 5 times with no corruption.
- Simultaneous at boundary: at count=3, push+pop in the same cycle -> `count` stays 3. At count=4 with a_valid=1 and b_ready=1 -> only the pop occurs and `count`=3.
- Flush: with count=3, assert flush together with a_valid=1 and b_ready=1 -> next cycle `count`=0, `b_valid`=0, `a_ready`=1; the pushed word is never output.
- Async reset mid-stream: drop rst between edges at count=2 -> outputs go to reset values immediately without waiting for a clock edge; after release, the first pushed word 0xABC is the first word output.
